// File: rtl/parking_pkg.sv
// Shared types and constants for the parking gate controller.
package parking_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    OPEN_ENTRY = 2'd1,
    OPEN_EXIT  = 2'd2,
    CLOSE      = 2'd3
  } gate_state_t;

  localparam int PARKING_CAPACITY = 10;
  localparam int PARKING_INIT     = 5;
  localparam int REFUSE_W         = 8;

  // Saturating increment for the refused-entry statistic.
  function automatic logic [REFUSE_W-1:0] sat_inc(input logic [REFUSE_W-1:0] v);
    if (v == {REFUSE_W{1'b1}}) begin
      return v;
    end else begin
      return v + REFUSE_W'(1);
    end
  endfunction

endpackage

// File: rtl/parking_gate_chk.sv
// Property checker for the parking gate controller: the occupancy count
// stays within its range and the two barriers are never open together.
module parking_gate_chk #(
  parameter int CAPACITY = 10,
  parameter int CNT_W    = 4
) (
  input logic             clk,
  input logic             rst_n,
  input logic [CNT_W-1:0] num,
  input logic             entry_gnt,
  input logic             exit_gnt,
  input logic             entry_gate_open,
  input logic             exit_gate_open
);

  a_num_range: assert property (@(posedge clk) disable iff (!rst_n)
    num <= CNT_W'(CAPACITY));

  a_one_gate: assert property (@(posedge clk) disable iff (!rst_n)
    !(entry_gate_open && exit_gate_open));

  a_one_gnt: assert property (@(posedge clk) disable iff (!rst_n)
    !(entry_gnt && exit_gnt));

endmodule

// File: rtl/parking_gate_timer.sv
// Gate-open down-timer shared by both OPEN states. Loaded on a grant with
// OPEN_CYCLES-1 so that the load cycle plus the count-down spans exactly
// OPEN_CYCLES cycles; done is high once the count reaches zero.
module parking_gate_timer #(
  parameter int OPEN_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic dec,
  output logic done
);

  localparam int TW = $clog2(OPEN_CYCLES + 1);
  localparam logic [TW-1:0] LOAD_VAL = TW'(OPEN_CYCLES - 1);

  logic [TW-1:0] cnt_r;

  // Load on grant, otherwise count down to zero while a gate is open.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= '0;
    end else if (load) begin
      cnt_r <= LOAD_VAL;
    end else if (dec && (cnt_r != '0)) begin
      cnt_r <= cnt_r - TW'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign done = (cnt_r == '0);

endmodule

// File: rtl/parking_gate_ctrl.sv
// Parking gate sequencer/arbiter: grants entry or exit one at a time with
// round-robin on ties, holds the chosen barrier open for OPEN_CYCLES, then
// closes for one cycle. Optional macro PARKING_STATS_EN adds refused_cnt.
module parking_gate_ctrl
  import parking_pkg::*;
#(
  parameter int CAPACITY    = PARKING_CAPACITY,
  parameter int INIT_COUNT  = PARKING_INIT,
  parameter int OPEN_CYCLES = 4,
  parameter int CNT_W       = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             entry_req,
  input  logic             exit_req,
  output logic             entry_gnt,
  output logic             exit_gnt,
  output logic             entry_gate_open,
  output logic             exit_gate_open,
  output logic [CNT_W-1:0] num,
  output logic             full,
  output logic             empty,
  output logic             busy
`ifdef PARKING_STATS_EN
  ,output logic [REFUSE_W-1:0] refused_cnt
`endif
);

  gate_state_t      state_r, state_s;
  logic             last_entry_r, last_entry_s;
  logic             entry_ok_s, exit_ok_s;
  logic             timer_load_s, timer_dec_s, timer_done_s;
  logic             entry_gnt_s, exit_gnt_s, entry_open_s, exit_open_s;
  logic             busy_s, full_s, empty_s;
  logic [CNT_W-1:0] num_s;

  assign entry_ok_s  = entry_req & ~full;
  assign exit_ok_s   = exit_req & ~empty;
  assign timer_dec_s = (state_r == OPEN_ENTRY) || (state_r == OPEN_EXIT);

  parking_gate_timer #(.OPEN_CYCLES(OPEN_CYCLES)) u_timer (
    .clk  (clk),
    .rst_n(rst_n),
    .load (timer_load_s),
    .dec  (timer_dec_s),
    .done (timer_done_s)
  );

  // State and round-robin pointer registers; pointer resets to "entry last".
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= IDLE;
      last_entry_r <= 1'b1;
    end else begin
      state_r      <= state_s;
      last_entry_r <= last_entry_s;
    end
  end

  // Next-state logic with arbitration between eligible requests.
  always_comb begin
    state_s      = state_r;
    last_entry_s = last_entry_r;
    timer_load_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (entry_ok_s && exit_ok_s) begin
          timer_load_s = 1'b1;
          if (last_entry_r) begin
            state_s      = OPEN_EXIT;
            last_entry_s = 1'b0;
          end else begin
            state_s      = OPEN_ENTRY;
            last_entry_s = 1'b1;
          end
        end else if (entry_ok_s) begin
          timer_load_s = 1'b1;
          state_s      = OPEN_ENTRY;
          last_entry_s = 1'b1;
        end else if (exit_ok_s) begin
          timer_load_s = 1'b1;
          state_s      = OPEN_EXIT;
          last_entry_s = 1'b0;
        end else begin
          state_s = IDLE;
        end
      end
      OPEN_ENTRY: begin
        if (timer_done_s) begin
          state_s = CLOSE;
        end else begin
          state_s = OPEN_ENTRY;
        end
      end
      OPEN_EXIT: begin
        if (timer_done_s) begin
          state_s = CLOSE;
        end else begin
          state_s = OPEN_EXIT;
        end
      end
      CLOSE:   state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // Next values of the registered outputs, derived from the chosen transition.
  always_comb begin
    entry_gnt_s  = (state_r == IDLE) && (state_s == OPEN_ENTRY);
    exit_gnt_s   = (state_r == IDLE) && (state_s == OPEN_EXIT);
    entry_open_s = (state_s == OPEN_ENTRY);
    exit_open_s  = (state_s == OPEN_EXIT);
    busy_s       = (state_s != IDLE);
    if (entry_gnt_s) begin
      num_s = num + CNT_W'(1);
    end else if (exit_gnt_s) begin
      num_s = num - CNT_W'(1);
    end else begin
      num_s = num;
    end
    full_s  = (num_s == CNT_W'(CAPACITY));
    empty_s = (num_s == '0);
  end

  // Output registers; reset closes both gates immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      entry_gnt       <= 1'b0;
      exit_gnt        <= 1'b0;
      entry_gate_open <= 1'b0;
      exit_gate_open  <= 1'b0;
      busy            <= 1'b0;
      num             <= CNT_W'(INIT_COUNT);
      full            <= (INIT_COUNT == CAPACITY);
      empty           <= (INIT_COUNT == 0);
    end else begin
      entry_gnt       <= entry_gnt_s;
      exit_gnt        <= exit_gnt_s;
      entry_gate_open <= entry_open_s;
      exit_gate_open  <= exit_open_s;
      busy            <= busy_s;
      num             <= num_s;
      full            <= full_s;
      empty           <= empty_s;
    end
  end

`ifdef PARKING_STATS_EN
  logic entry_req_q_r;

  // Count new entry requests that arrive while the lot is full.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      entry_req_q_r <= 1'b0;
      refused_cnt   <= '0;
    end else begin
      entry_req_q_r <= entry_req;
      if (entry_req && !entry_req_q_r && full) begin
        refused_cnt <= sat_inc(refused_cnt);
      end else begin
        refused_cnt <= refused_cnt;
      end
    end
  end
`endif

  parking_gate_chk #(.CAPACITY(CAPACITY), .CNT_W(CNT_W)) u_chk (
    .clk            (clk),
    .rst_n          (rst_n),
    .num            (num),
    .entry_gnt      (entry_gnt),
    .exit_gnt       (exit_gnt),
    .entry_gate_open(entry_gate_open),
    .exit_gate_open (exit_gate_open)
  );

endmodule
